// File: rtl/json_decode_arbiter.sv
// json_decode_arbiter: round-robin sharing of one JSON decoder core among NREQ requesters.
// Ports: clk/rst_n; req_* per-requester document byte streams; rsp_* one-hot result handshake
//        with shared err/kind/pos; dec_* start/abort pulses, byte stream and completion result
//        exchanged with the decoder; busy/grant_id session status.
module json_decode_arbiter #(
  parameter int NREQ = 4,
  parameter int POS_W = 16,
  parameter int TIMEOUT = 1024,
  localparam int GW = $clog2(NREQ),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_byte_valid,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic [NREQ-1:0]   req_byte_last,
  output logic [NREQ-1:0]   req_byte_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              rsp_err,
  output logic [3:0]        rsp_kind,
  output logic [POS_W-1:0]  rsp_pos,
  output logic              dec_start,
  output logic              dec_byte_valid,
  output logic [7:0]        dec_byte,
  output logic              dec_byte_last,
  input  logic              dec_byte_ready,
  input  logic              dec_done,
  input  logic              dec_err,
  input  logic [3:0]        dec_kind,
  input  logic [POS_W-1:0]  dec_pos,
  output logic              dec_abort,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);
  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [POS_W-1:0] cnt_q, cnt_d, pos_q, pos_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  logic [3:0] kind_q, kind_d;
  logic stream, g_valid, g_last, xfer;
  logic [7:0] g_byte;
  // Walk downward so the lowest offset from last_grant+1 is the one that sticks.
  always_comb begin
    pick = last_q;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[(int'(last_q) + k) % NREQ]) pick = GW'((int'(last_q) + k) % NREQ);
  end
  assign stream = state_q == STREAM;
  assign g_valid = req_byte_valid[grant_q];
  assign g_last = req_byte_last[grant_q];
  assign g_byte = req_byte[{grant_q, 3'b000} +: 8];
  assign xfer = dec_byte_valid && dec_byte_ready;
  assign dec_start = state_q == START;
  assign dec_byte_valid = stream && g_valid;
  assign dec_byte = stream ? g_byte : 8'h00;
  assign dec_byte_last = stream && g_last;
  assign req_byte_ready = (stream ? NREQ'(dec_byte_ready) : state_q == DRAIN ? NREQ'(1'b1) : '0) << grant_q;
  assign rsp_valid = (state_q == RESP ? NREQ'(1'b1) : '0) << grant_q;
  assign dec_abort = state_q == WAIT && !dec_done && tmo_q == TW'(TIMEOUT - 1);
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign rsp_err = err_q;
  assign rsp_kind = kind_q;
  assign rsp_pos = pos_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    err_d = err_q;
    kind_d = kind_q;
    pos_d = pos_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = pick;
        state_d = START;
      end
      START: begin
        cnt_d = '0;
        state_d = STREAM;
      end
      STREAM: begin
        cnt_d = (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        if (dec_done) begin
          err_d = dec_err;
          kind_d = dec_kind;
          pos_d = dec_pos;
          state_d = (xfer && g_last) ? RESP : DRAIN;
        end else if (xfer && g_last) begin
          tmo_d = '0;
          state_d = WAIT;
        end
      end
      DRAIN: state_d = (g_valid && g_last) ? RESP : DRAIN;
      WAIT: if (dec_done) begin
        err_d = dec_err;
        kind_d = dec_kind;
        pos_d = dec_pos;
        state_d = RESP;
      end else if (dec_abort) begin
        err_d = 1'b1;
        kind_d = 4'hF;
        pos_d = cnt_q;
        state_d = RESP;
      end else tmo_d = tmo_q + 1'b1;
      RESP: if (rsp_ready[grant_q]) begin
        last_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NREQ - 1);
      cnt_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      kind_q <= '0;
      pos_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      kind_q <= kind_d;
      pos_q <= pos_d;
    end
endmodule

// File: tb/tb_json_decode_arbiter.sv
// tb_json_decode_arbiter: directed sessions against a session-level model, checked every cycle.
module tb_json_decode_arbiter;
  localparam int NREQ = 4, POS_W = 16, TIMEOUT = 8, GW = 2;
  localparam int M_AFTER = 0, M_EARLY = 1, M_SAME = 2, M_TMO = 3;
  logic clk = 0, rst_n;
  logic [NREQ-1:0] req_valid, req_byte_valid, req_byte_last, req_byte_ready, rsp_valid, rsp_ready;
  logic [8*NREQ-1:0] req_byte;
  logic rsp_err, dec_start, dec_byte_valid, dec_byte_last, dec_byte_ready, dec_done, dec_err, dec_abort, busy;
  logic [3:0] rsp_kind, dec_kind;
  logic [POS_W-1:0] rsp_pos, dec_pos;
  logic [7:0] dec_byte;
  logic [GW-1:0] grant_id;
  always #5 clk = ~clk;
  json_decode_arbiter #(.NREQ(NREQ), .POS_W(POS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_byte_valid(req_byte_valid),
    .req_byte(req_byte), .req_byte_last(req_byte_last), .req_byte_ready(req_byte_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_kind(rsp_kind),
    .rsp_pos(rsp_pos), .dec_start(dec_start), .dec_byte_valid(dec_byte_valid), .dec_byte(dec_byte),
    .dec_byte_last(dec_byte_last), .dec_byte_ready(dec_byte_ready), .dec_done(dec_done),
    .dec_err(dec_err), .dec_kind(dec_kind), .dec_pos(dec_pos), .dec_abort(dec_abort),
    .busy(busy), .grant_id(grant_id));
  int checks = 0, failures = 0;
  logic e_busy, e_start, e_abort, e_dvalid, e_dlast, e_rspv_on, e_err;
  logic [7:0] e_dbyte;
  logic [3:0] e_kind;
  logic [POS_W-1:0] e_pos;
  logic [NREQ-1:0] e_rbr;
  int e_grant = 0, m_last;
  logic [7:0] doc [0:15];
  int gseq[$];
  int cyc = 0, n_start = 0, n_xfer = 0, n_rx = 0, n_abort = 0, t_lastx = 0, t_abort = 0, t_rsp = 0;
  logic rspv_prev = 0, seen_err = 0;
  logic [NREQ-1:0] seen_rspv = 0;
  logic [3:0] seen_kind = 0;
  logic [POS_W-1:0] seen_pos = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [NREQ-1:0] ev;
    cyc++;
    ev = e_rspv_on ? (NREQ'(1) << e_grant) : '0;
    chk("busy", busy, e_busy);
    if (e_busy) chk("grant_id", grant_id, e_grant);
    chk("dec_start", dec_start, e_start);
    chk("dec_abort", dec_abort, e_abort);
    chk("dec_byte_valid", dec_byte_valid, e_dvalid);
    if (e_dvalid) begin
      chk("dec_byte", dec_byte, e_dbyte);
      chk("dec_byte_last", dec_byte_last, e_dlast);
    end
    chk("req_byte_ready", req_byte_ready, e_rbr);
    chk("rsp_valid", rsp_valid, ev);
    if (e_rspv_on) begin
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_kind", rsp_kind, e_kind);
      chk("rsp_pos", rsp_pos, e_pos);
    end
    if (dec_start) n_start++;
    if (dec_abort) begin n_abort++; t_abort = cyc; end
    if (dec_byte_valid && dec_byte_ready) begin n_xfer++; if (dec_byte_last) t_lastx = cyc; end
    if ((req_byte_ready & req_byte_valid) != 0) n_rx++;
    if (rsp_valid != 0) begin
      if (!rspv_prev) t_rsp = cyc;
      seen_rspv = rsp_valid; seen_err = rsp_err; seen_kind = rsp_kind; seen_pos = rsp_pos;
    end
    rspv_prev = rsp_valid != 0;
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic clr_exp;
    e_busy = 0; e_start = 0; e_abort = 0; e_dvalid = 0; e_dlast = 0; e_dbyte = 0;
    e_rbr = 0; e_rspv_on = 0; e_err = 0; e_kind = 0; e_pos = 0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {busy, dec_start, dec_abort, dec_byte_valid, dec_byte_last, rsp_err}, 0);
    chk({tag, "_req_byte_ready"}, req_byte_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_dec_byte"}, dec_byte, 0);
    chk({tag, "_rsp_kind"}, rsp_kind, 0);
    chk({tag, "_rsp_pos"}, rsp_pos, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask
  function automatic int rr(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction
  // Granted requester shows its document; the others show decoy bytes flagged as last.
  task automatic drive_bytes(input int g, input int idx, input int n);
    for (int i = 0; i < NREQ; i++) begin
      req_byte_valid[i] = (i == g) ? idx < n : 1'b1;
      req_byte[8*i +: 8] = (i == g) ? ((idx < n) ? doc[idx] : 8'h00) : 8'hA0 + 8'(i);
      req_byte_last[i] = (i == g) ? idx == n - 1 : 1'b1;
    end
  endtask
  task automatic session(input logic [NREQ-1:0] rv, input int n, input int mode, input int arg,
                         input logic err, input logic [3:0] kind, input logic [POS_W-1:0] pos,
                         input bit stall, input int rdly, input bit drop, input int rst_at);
    int g, idx, sc, nxt;
    logic rdy, done, r_err;
    logic [3:0] r_kind;
    logic [POS_W-1:0] r_pos;
    g = rr(m_last, rv);
    idx = 0; sc = 0; nxt = 0; r_err = 0; r_kind = 0; r_pos = 0;
    req_valid = rv; rsp_ready = 0; dec_done = 0; dec_byte_ready = 1;
    drive_bytes(g, 0, n);
    clr_exp; tick;
    gseq.push_back(int'(grant_id));
    if (drop) req_valid = 0;
    clr_exp; e_busy = 1; e_grant = g; e_start = 1; tick;
    for (int c = 0; c < 4 * n + 8; c++) begin
      rdy = !(stall && sc % 3 == 1);
      done = (mode == M_EARLY && idx == arg) || (mode == M_SAME && idx == n - 1 && rdy);
      if (mode == M_EARLY && done) rdy = 0;
      dec_byte_ready = rdy; dec_done = done;
      dec_err = done ? err : 1'b0; dec_kind = done ? kind : 4'h0; dec_pos = done ? pos : '0;
      drive_bytes(g, idx, n);
      clr_exp; e_busy = 1; e_grant = g; e_dvalid = 1; e_dbyte = doc[idx]; e_dlast = idx == n - 1;
      e_rbr = rdy ? NREQ'(1) << g : '0;
      if (sc == rst_at) begin
        #2 rst_n = 0;
        #1 chk_all_zero("async_reset");
        req_valid = 0; req_byte_valid = 0; req_byte = 0; req_byte_last = 0;
        dec_done = 0; dec_err = 0; dec_kind = 0; dec_pos = 0;
        clr_exp; m_last = NREQ - 1;
        tick; rst_n = 1;
        return;
      end
      tick; sc++;
      if (done) begin
        r_err = err; r_kind = kind; r_pos = pos;
        nxt = (rdy && idx == n - 1) ? 2 : 1;
        if (rdy) idx++;
        break;
      end
      if (rdy) begin idx++; if (idx == n) break; end
    end
    dec_done = 0;
    if (nxt == 1)
      for (int c = 0; c < n && idx < n; c++) begin
        drive_bytes(g, idx, n);
        dec_done = c == 0; dec_err = 0; dec_kind = 4'h9; dec_pos = 16'd77;
        clr_exp; e_busy = 1; e_grant = g; e_rbr = NREQ'(1) << g;
        tick; idx++;
      end
    if (nxt == 0)
      for (int w = 0; w < TIMEOUT; w++) begin
        drive_bytes(g, idx, n);
        done = mode == M_AFTER && w == arg - 1;
        dec_done = done; dec_err = done ? err : 1'b0; dec_kind = done ? kind : 4'h0; dec_pos = done ? pos : '0;
        clr_exp; e_busy = 1; e_grant = g; e_abort = mode == M_TMO && w == TIMEOUT - 1;
        tick;
        if (done) begin r_err = err; r_kind = kind; r_pos = pos; break; end
        if (e_abort) begin r_err = 1; r_kind = 4'hF; r_pos = POS_W'(n); break; end
      end
    dec_done = 0;
    drive_bytes(g, n, n);
    for (int c = 0; c <= rdly; c++) begin
      rsp_ready = (c == rdly) ? NREQ'(1) << g : ~(NREQ'(1) << g);
      clr_exp; e_busy = 1; e_grant = g; e_rspv_on = 1; e_err = r_err; e_kind = r_kind; e_pos = r_pos;
      tick;
    end
    rsp_ready = 0; m_last = g;
  endtask
  task automatic idle(input int n, input bit spurious);
    req_valid = 0; dec_done = spurious; dec_err = spurious; dec_kind = 4'h5; dec_pos = 16'd33;
    clr_exp;
    repeat (n) tick;
    dec_done = 0; dec_err = 0;
  endtask
  initial begin
    #200000 $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    int s_start, s_xfer, s_rx, s_abort;
    rst_n = 0; req_valid = 0; req_byte_valid = 0; req_byte = 0; req_byte_last = 0; rsp_ready = 0;
    dec_byte_ready = 0; dec_done = 0; dec_err = 0; dec_kind = 0; dec_pos = 0;
    clr_exp; m_last = NREQ - 1;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 16; i++) doc[i] = 8'h40 + 8'(i);
    for (int s = 0; s < 5; s++) session(4'hF, 2, M_AFTER, 1, 0, 4'h0, POS_W'(s + 1), s == 2, (s == 1) ? 2 : 0, 0, -1);
    for (int s = 0; s < 5; s++) chk("rr_order", gseq[s], ord[s]);
    doc[0] = 8'h5B; doc[1] = 8'h31; doc[2] = 8'h5D;
    s_start = n_start; s_xfer = n_xfer;
    session(4'b0100, 3, M_AFTER, 2, 0, 4'h0, 16'd3, 0, 1, 0, -1);
    chk("doc3_starts", n_start - s_start, 1);
    chk("doc3_xfers", n_xfer - s_xfer, 3);
    chk("doc3_rsp_valid", seen_rspv, 4'b0100);
    chk("doc3_rsp_pos", seen_pos, 3);
    for (int i = 0; i < 6; i++) doc[i] = 8'h61 + 8'(i);
    s_xfer = n_xfer; s_rx = n_rx;
    session(4'b0010, 6, M_EARLY, 2, 1, 4'h3, 16'd1, 0, 0, 0, -1);
    chk("early_dec_xfers", n_xfer - s_xfer, 2);
    chk("early_drained", (n_rx - s_rx) - (n_xfer - s_xfer), 4);
    chk("early_result", {seen_err, seen_kind, seen_pos}, {1'b1, 4'h3, 16'd1});
    s_abort = n_abort;
    session(4'b1000, 5, M_TMO, 0, 0, 4'h0, '0, 0, 0, 0, -1);
    chk("tmo_abort_pulses", n_abort - s_abort, 1);
    chk("tmo_abort_delay", t_abort - t_lastx, 8);
    chk("tmo_result", {seen_err, seen_kind, seen_pos}, {1'b1, 4'hF, 16'd5});
    session(4'b0001, 3, M_SAME, 0, 0, 4'h2, 16'd9, 1, 0, 0, -1);
    chk("same_cycle_rsp_delay", t_rsp - t_lastx, 1);
    chk("same_cycle_grant", gseq[gseq.size() - 1], 0);
    session(4'b0110, 2, M_AFTER, 3, 0, 4'h0, 16'd2, 0, 0, 1, -1);
    chk("drop_grant", gseq[gseq.size() - 1], 1);
    idle(3, 1);
    session(4'hF, 4, M_AFTER, 1, 0, 4'h0, '0, 0, 0, 0, 1);
    idle(1, 0);
    session(4'b0011, 2, M_AFTER, 1, 0, 4'h1, 16'd4, 0, 0, 0, -1);
    chk("post_reset_grant", gseq[gseq.size() - 1], 0);
    idle(2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
